data_sram_pipe: RTL and testbench

//  Parametrised byte-lane data memory with valid/ready request and response channels.

---
 rtl/data_sram_pipe_pkg.sv | 21 ++
 rtl/data_sram_lane.sv | 21 ++
 rtl/data_sram_pipe.sv | 118 +++++++++++
 tb/tb_data_sram_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_pipe_pkg.sv
// Shared constants and types for the pipelined byte-lane data memory.
// Holds latency bounds, legal select patterns and the stage control bundle.
package data_sram_pipe_pkg;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   // Naturally aligned halfword select, shifted by 2k per pair.
   localparam logic [1:0] SEL_HALF = 2'b11;

   typedef struct packed {
      logic valid;
      logic we;
      logic err;
   } stage_ctl_t;

   function automatic logic lat_ok(input int lat);
      return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
   endfunction

endpackage

// File: rtl/data_sram_lane.sv
// One byte-wide storage lane: synchronous write, registered read.
// Ports: clk, we/re strobes, word addr, wdata byte, rdata byte.
module data_sram_lane #(
   parameter int DEPTH_LOG2 = 17
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [7:0]            wdata,
   output logic [7:0]            rdata
);

   logic [7:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_sram_pipe.sv
// Byte-lane data memory with valid/ready request and response channels.
// Ports: clk, resetn, req_{valid,ready,we,addr,sel,wdata},
//        resp_{valid,ready,rdata,err}. Read latency READ_LAT (1 or 2).
module data_sram_pipe
   import data_sram_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH_LOG2 = 17,
   parameter int READ_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH/8-1:0] req_sel,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(BYTES);

   if (!lat_ok(READ_LAT) || (DATA_WIDTH % 8) != 0 ||
       (DEPTH_LOG2 + OFS) > ADDR_WIDTH) begin : g_bad_param
      $error("data_sram_pipe: illegal parameters");
   end

   logic                  stall;
   logic                  accept;
   logic                  sel_ok;
   logic                  addr_ok;
   logic                  err_in;
   logic [DEPTH_LOG2-1:0] idx;
   logic [DATA_WIDTH-1:0] lane_q;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [DATA_WIDTH-1:0] last_data;
   stage_ctl_t            s1;
   stage_ctl_t            last;

   assign stall     = last.valid && !resp_ready;
   assign req_ready = resetn && !stall;
   assign accept    = req_valid && req_ready;

   assign idx     = req_addr[DEPTH_LOG2+OFS-1:OFS];
   assign addr_ok = (req_addr >> (DEPTH_LOG2 + OFS)) == '0;

   // Legal selects: one byte, an aligned halfword pair, or all lanes.
   always_comb begin
      sel_ok = (&req_sel) || $onehot(req_sel);
      for (int k = 0; k < BYTES / 2; k++) begin
         if (req_sel == (BYTES'(SEL_HALF) << (2 * k)))
            sel_ok = 1'b1;
      end
   end

   assign err_in = !sel_ok || !addr_ok;

   if (OFS > 0) begin : g_ofs
      logic unused_ofs;
      assign unused_ofs = &{1'b0, req_addr[OFS-1:0]};
   end

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      data_sram_lane #(
         .DEPTH_LOG2(DEPTH_LOG2)
      ) u_lane (
         .clk   (clk),
         .we    (accept && req_we && !err_in && req_sel[i]),
         .re    (accept && !req_we && !err_in),
         .addr  (idx),
         .wdata (req_wdata[8*i +: 8]),
         .rdata (lane_q[8*i +: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1 <= '0;
      end else if (!stall) begin
         s1 <= '{valid: accept, we: req_we, err: err_in};
      end
   end

   // Lane outputs only carry meaning for a legal read in S1.
   assign s1_data = (s1.valid && !s1.we && !s1.err) ? lane_q : '0;

   if (READ_LAT == 2) begin : g_s2
      stage_ctl_t            s2;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk) begin
         if (!resetn) begin
            s2      <= '0;
            s2_data <= '0;
         end else if (!stall) begin
            s2      <= s1;
            s2_data <= s1_data;
         end
      end

      assign last      = s2;
      assign last_data = s2_data;
   end else begin : g_s1
      assign last      = s1;
      assign last_data = s1_data;
   end

   assign resp_valid = last.valid;
   assign resp_err   = last.err;
   assign resp_rdata = last_data;

endmodule

// File: tb/tb_data_sram_pipe.sv
// Scoreboard bench for data_sram_pipe, one instance per read latency.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_data_sram_pipe;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      bit          chk_lat;
   } exp_t;

   logic        clk = 0;
   logic        resetn;
   logic        rqv   [2];
   logic        rqr   [2];
   logic        rqwe  [2];
   logic [31:0] rqa   [2];
   logic [3:0]  rqs   [2];
   logic [31:0] rqwd  [2];
   logic        rsv   [2];
   logic        rsr   [2];
   logic [31:0] rsd   [2];
   logic        rse   [2];

   exp_t q0[$];
   exp_t q1[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   first [2];
   bit   seen  [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   data_sram_pipe #(.READ_LAT(1)) u_l1 (
      .clk(clk), .resetn(resetn),
      .req_valid(rqv[0]), .req_ready(rqr[0]), .req_we(rqwe[0]),
      .req_addr(rqa[0]), .req_sel(rqs[0]), .req_wdata(rqwd[0]),
      .resp_valid(rsv[0]), .resp_ready(rsr[0]),
      .resp_rdata(rsd[0]), .resp_err(rse[0])
   );

   data_sram_pipe #(.READ_LAT(2)) u_l2 (
      .clk(clk), .resetn(resetn),
      .req_valid(rqv[1]), .req_ready(rqr[1]), .req_we(rqwe[1]),
      .req_addr(rqa[1]), .req_sel(rqs[1]), .req_wdata(rqwd[1]),
      .resp_valid(rsv[1]), .resp_ready(rsr[1]),
      .resp_rdata(rsd[1]), .resp_err(rse[1])
   );

   task automatic chk(input string nm, input int d,
                      input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s d%0d got=%h exp=%h t=%0t", nm, d, got, exp, $time);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qhead(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpop(input int d);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic qpush(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor: compare head while valid (covers held data), pop on handshake.
   always @(negedge clk) begin
      exp_t h;
      for (int d = 0; d < 2; d++) begin
         if (resetn && rsv[d]) begin
            if (qsize(d) == 0) begin
               chk("unexpected_resp", d, 32'(rsv[d]), 32'd0);
            end else begin
               h = qhead(d);
               chk("rdata", d, rsd[d], h.rdata);
               chk("err", d, 32'(rse[d]), 32'(h.err));
               if (!seen[d]) begin
                  seen[d]  = 1;
                  first[d] = cyc;
               end
               if (!rsr[d]) begin
                  chk("req_ready_stall", d, 32'(rqr[d]), 32'd0);
               end else begin
                  if (h.chk_lat)
                     chk("latency", d, 32'(first[d] - h.acc + 1), 32'(d + 1));
                  qpop(d);
                  seen[d] = 0;
               end
            end
         end
      end
   end

   task automatic issue(input int d, input bit we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee, input bit cl);
      int n;
      exp_t e;
      rqv[d] = 1; rqwe[d] = we; rqa[d] = a; rqs[d] = s; rqwd[d] = wd;
      n = 0;
      @(negedge clk);
      while (!rqr[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rqr[d]) begin
         chk("accept_timeout", d, 32'(rqr[d]), 32'd1);
      end else begin
         e.rdata = er; e.err = ee; e.acc = cyc + 1; e.chk_lat = cl;
         qpush(d, e);
      end
      @(posedge clk);
      #1 rqv[d] = 0;
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (qsize(d) != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (qsize(d) != 0) chk("drain_timeout", d, 32'(qsize(d)), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 0;
      for (int d = 0; d < 2; d++) begin
         rqv[d] = 0; rqwe[d] = 0; rqa[d] = 0; rqs[d] = 0; rqwd[d] = 0;
         rsr[d] = 1; seen[d] = 0; first[d] = 0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("rst_req_ready", d, 32'(rqr[d]), 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_resp_valid", d, 32'(rsv[d]), 0);
         chk("rst_resp_rdata", d, rsd[d], 0);
         chk("rst_resp_err", d, 32'(rse[d]), 0);
         chk("post_rst_ready", d, 32'(rqr[d]), 1);
      end
      @(posedge clk);
      #1;

      // full write then read, latency 1
      issue(0, 1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 1);
      issue(0, 0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 1);
      drain(0);

      // single-lane and halfword writes
      issue(0, 1, 32'h10, 4'b0100, 32'h00AA0000, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 0, 0);
      issue(0, 1, 32'h10, 4'b0010, 32'h00005500, 32'h0, 0, 0);
      issue(0, 1, 32'h10, 4'b1000, 32'h11000000, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 4'b1111, 32'h0, 32'h11AA55EF, 0, 0);
      issue(0, 1, 32'h10, 4'b0011, 32'hFFFF1234, 32'h0, 0, 0);
      issue(0, 0, 32'h10, 4'b1111, 32'h0, 32'h11AA1234, 0, 0);
      drain(0);

      // illegal accesses leave the array alone
      issue(0, 1, 32'h10, 4'b0110, 32'hFFFFFFFF, 32'h0, 1, 1);
      issue(0, 1, 32'h10, 4'b0101, 32'hFFFFFFFF, 32'h0, 1, 0);
      issue(0, 0, 32'h10, 4'b0000, 32'h0, 32'h0, 1, 0);
      issue(0, 1, 32'h0008_0010, 4'b1111, 32'hFFFFFFFF, 32'h0, 1, 0);
      issue(0, 0, 32'h0008_0010, 4'b1111, 32'h0, 32'h0, 1, 0);
      issue(0, 0, 32'h10, 4'b1111, 32'h0, 32'h11AA1234, 0, 0);
      issue(0, 0, 32'h13, 4'b0001, 32'h0, 32'h11AA1234, 0, 0);
      drain(0);

      // write then read back-to-back at both latencies
      issue(0, 1, 32'h24, 4'b1111, 32'h12345678, 32'h0, 0, 1);
      issue(0, 0, 32'h24, 4'b1111, 32'h0, 32'h12345678, 0, 1);
      drain(0);
      issue(1, 1, 32'h20, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 1);
      issue(1, 0, 32'h20, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 1);
      drain(1);

      // four reads with a 3-cycle response stall mid-stream
      for (int i = 0; i < 4; i++)
         issue(1, 1, 32'h40 + 32'(4 * i), 4'b1111, 32'hA0A0A0A0 + 32'(i),
               32'h0, 0, 0);
      drain(1);
      fork
         begin
            for (int i = 0; i < 4; i++)
               issue(1, 0, 32'h40 + 32'(4 * i), 4'b1111, 32'h0,
                     32'hA0A0A0A0 + 32'(i), 0, 0);
         end
         begin
            repeat (2) @(posedge clk);
            #2 rsr[1] = 0;
            repeat (3) @(posedge clk);
            #2 rsr[1] = 1;
         end
      join
      drain(1);

      // reset with two reads in flight
      rsr[1] = 0;
      issue(1, 0, 32'h40, 4'b1111, 32'h0, 32'hA0A0A0A0, 0, 0);
      issue(1, 0, 32'h44, 4'b1111, 32'h0, 32'hA0A0A0A1, 0, 0);
      resetn = 0;
      q1.delete();
      seen[1] = 0;
      @(negedge clk);
      chk("rst_mid_req_ready", 1, 32'(rqr[1]), 0);
      @(posedge clk);
      #1 resetn = 1;
      rsr[1] = 1;
      repeat (4) begin
         @(negedge clk);
         chk("no_late_resp", 1, 32'(rsv[1]), 0);
      end
      @(posedge clk);
      #1;
      issue(1, 0, 32'h40, 4'b1111, 32'h0, 32'hA0A0A0A0, 0, 1);
      issue(0, 0, 32'h10, 4'b1111, 32'h0, 32'h11AA1234, 0, 1);
      drain(1);
      drain(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
